// File: rtl/hbm_tg_pkg.sv
// Shared state encoding, AXI constants and pattern/error helpers for the
// HBM AXI traffic generator.
package hbm_tg_pkg;

  typedef enum logic [2:0] {
    TG_IDLE    = 3'd0,
    TG_WR_ADDR = 3'd1,
    TG_WR_DATA = 3'd2,
    TG_WR_RESP = 3'd3,
    TG_RD_ADDR = 3'd4,
    TG_RD_DATA = 3'd5,
    TG_DONE    = 3'd6
  } tg_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // One 32-bit lane of the test pattern: burst index, beat index, lane index.
  function automatic logic [31:0] pattern_lane(input logic [15:0] burst_idx,
                                               input logic [7:0]  beat_idx,
                                               input logic [7:0]  lane_idx);
    return {burst_idx, beat_idx, lane_idx};
  endfunction

  // Error counter add that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] err_sat_add(input logic [15:0] cnt,
                                              input logic [2:0]  inc);
    logic [16:0] sum;
    sum = {1'b0, cnt} + {14'd0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/hbm_axi_traffic_gen_if.sv
// AXI4 bus bundle between the traffic generator (master) and one memory
// channel (slave).
interface hbm_axi_traffic_gen_if #(
  parameter int ADDR_WIDTH = 33,
  parameter int DATA_WIDTH = 256,
  parameter int ID_WIDTH   = 9
);
  logic                    awvalid;
  logic                    awready;
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    bvalid;
  logic                    bready;
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    arvalid;
  logic                    arready;
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    rvalid;
  logic                    rready;
  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;

  modport master (
    output awvalid, awid, awaddr, awlen, awsize, awburst,
    output wvalid, wdata, wstrb, wlast, bready,
    output arvalid, arid, araddr, arlen, arsize, arburst, rready,
    input  awready, wready, bvalid, bid, bresp,
    input  arready, rvalid, rid, rdata, rresp, rlast
  );

  modport slave (
    input  awvalid, awid, awaddr, awlen, awsize, awburst,
    input  wvalid, wdata, wstrb, wlast, bready,
    input  arvalid, arid, araddr, arlen, arsize, arburst, rready,
    output awready, wready, bvalid, bid, bresp,
    output arready, rvalid, rid, rdata, rresp, rlast
  );
endinterface

// File: rtl/hbm_tg_pattern.sv
// Combinational beat generator: full data word for a given burst and beat,
// shared by the write data path and the read checker.
module hbm_tg_pattern
  import hbm_tg_pkg::*;
#(
  parameter int DATA_WIDTH = 256
) (
  input  logic [15:0]           burst_idx,
  input  logic [7:0]            beat_idx,
  output logic [DATA_WIDTH-1:0] data
);
  localparam int LANES = DATA_WIDTH / 32;

  // Fill every 32-bit lane with its pattern word.
  always_comb begin
    data = '0;
    for (int k = 0; k < LANES; k++) begin
      data[k*32 +: 32] = pattern_lane(burst_idx, beat_idx, 8'(k));
    end
  end
endmodule

// File: rtl/hbm_axi_traffic_gen.sv
// AXI4 write/read-back/compare traffic generator for one HBM channel:
// per burst it writes a known pattern, reads it back and counts errors.
module hbm_axi_traffic_gen
  import hbm_tg_pkg::*;
#(
  parameter int ADDR_WIDTH = 33,
  parameter int DATA_WIDTH = 256,
  parameter int ID_WIDTH   = 9,
  parameter int BURST_LEN  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [15:0]           num_bursts,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           err_count,
  hbm_axi_traffic_gen_if.master axi
);
  localparam logic [7:0]            LAST_BEAT   = 8'(BURST_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BURST_LEN * (DATA_WIDTH / 8));
  localparam logic [2:0]            BEAT_SIZE   = 3'($clog2(DATA_WIDTH / 8));

  tg_state_e             state_r, state_nxt_s;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [15:0]           num_bursts_r, burst_cnt_r, err_cnt_r, err_nxt_s;
  logic [7:0]            beat_cnt_r;
  logic                  awvalid_r, wvalid_r, bready_r, arvalid_r, rready_r;
  logic                  busy_r, done_r, pass_r, done_nxt_s;
  logic                  accept_s, beat_last_s, last_burst_s;
  logic                  aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;
  logic                  b_err_s, r_data_err_s, r_resp_err_s, r_last_err_s;
  logic [2:0]            err_inc_s;
  logic [DATA_WIDTH-1:0] pattern_s;
  logic                  unused_id_s;

  assign accept_s     = (state_r == TG_IDLE) && start;
  assign beat_last_s  = (beat_cnt_r == LAST_BEAT);
  assign last_burst_s = ((burst_cnt_r + 16'd1) == num_bursts_r);
  assign aw_hs_s      = awvalid_r & axi.awready;
  assign w_hs_s       = wvalid_r & axi.wready;
  assign b_hs_s       = bready_r & axi.bvalid;
  assign ar_hs_s      = arvalid_r & axi.arready;
  assign r_hs_s       = rready_r & axi.rvalid;

  // Only one of W and R is ever active, so one generator serves both paths.
  hbm_tg_pattern #(.DATA_WIDTH(DATA_WIDTH)) u_pattern (
    .burst_idx (burst_cnt_r),
    .beat_idx  (beat_cnt_r),
    .data      (pattern_s)
  );

  assign b_err_s      = b_hs_s & (axi.bresp != AXI_RESP_OKAY);
  assign r_data_err_s = r_hs_s & (axi.rdata != pattern_s);
  assign r_resp_err_s = r_hs_s & (axi.rresp != AXI_RESP_OKAY);
  assign r_last_err_s = r_hs_s & (axi.rlast != beat_last_s);
  assign err_inc_s    = {2'b00, b_err_s} + {2'b00, r_data_err_s}
                      + {2'b00, r_resp_err_s} + {2'b00, r_last_err_s};
  assign done_nxt_s   = (state_nxt_s == TG_DONE) | (done_r & ~accept_s);

  // Next-state logic of the burst sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      TG_IDLE: begin
        if (start) state_nxt_s = (num_bursts == 16'd0) ? TG_DONE : TG_WR_ADDR;
        else       state_nxt_s = TG_IDLE;
      end
      TG_WR_ADDR: begin
        if (aw_hs_s) state_nxt_s = TG_WR_DATA;
        else         state_nxt_s = TG_WR_ADDR;
      end
      TG_WR_DATA: begin
        if (w_hs_s && beat_last_s) state_nxt_s = TG_WR_RESP;
        else                       state_nxt_s = TG_WR_DATA;
      end
      TG_WR_RESP: begin
        if (b_hs_s) state_nxt_s = TG_RD_ADDR;
        else        state_nxt_s = TG_WR_RESP;
      end
      TG_RD_ADDR: begin
        if (ar_hs_s) state_nxt_s = TG_RD_DATA;
        else         state_nxt_s = TG_RD_ADDR;
      end
      TG_RD_DATA: begin
        if (r_hs_s && beat_last_s) state_nxt_s = last_burst_s ? TG_DONE : TG_WR_ADDR;
        else                       state_nxt_s = TG_RD_DATA;
      end
      TG_DONE:  state_nxt_s = TG_IDLE;
      default:  state_nxt_s = TG_IDLE;
    endcase
  end

  // Error accumulation; a new run starts from zero.
  always_comb begin
    err_nxt_s = err_cnt_r;
    if (accept_s) err_nxt_s = 16'h0000;
    else          err_nxt_s = err_sat_add(err_cnt_r, err_inc_s);
  end

  // State register and channel controls, registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= TG_IDLE;
      awvalid_r <= 1'b0;
      wvalid_r  <= 1'b0;
      bready_r  <= 1'b0;
      arvalid_r <= 1'b0;
      rready_r  <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      pass_r    <= 1'b0;
      err_cnt_r <= 16'h0000;
    end else begin
      state_r   <= state_nxt_s;
      awvalid_r <= (state_nxt_s == TG_WR_ADDR);
      wvalid_r  <= (state_nxt_s == TG_WR_DATA);
      bready_r  <= (state_nxt_s == TG_WR_RESP);
      arvalid_r <= (state_nxt_s == TG_RD_ADDR);
      rready_r  <= (state_nxt_s == TG_RD_DATA);
      busy_r    <= (state_nxt_s != TG_IDLE) && (state_nxt_s != TG_DONE);
      done_r    <= done_nxt_s;
      pass_r    <= done_nxt_s && (err_nxt_s == 16'h0000);
      err_cnt_r <= err_nxt_s;
    end
  end

  // Run parameters, burst address/index and beat counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_r       <= '0;
      num_bursts_r <= 16'd0;
      burst_cnt_r  <= 16'd0;
      beat_cnt_r   <= 8'd0;
    end else begin
      if (accept_s) begin
        addr_r       <= base_addr;
        num_bursts_r <= num_bursts;
        burst_cnt_r  <= 16'd0;
      end else if (r_hs_s && beat_last_s) begin
        addr_r      <= addr_r + BURST_BYTES;
        burst_cnt_r <= burst_cnt_r + 16'd1;
      end else begin
        addr_r      <= addr_r;
        burst_cnt_r <= burst_cnt_r;
      end
      if (accept_s || aw_hs_s || ar_hs_s) beat_cnt_r <= 8'd0;
      else if (w_hs_s || r_hs_s)           beat_cnt_r <= beat_cnt_r + 8'd1;
      else                                 beat_cnt_r <= beat_cnt_r;
    end
  end

  assign axi.awvalid = awvalid_r;
  assign axi.awid    = {ID_WIDTH{1'b0}};
  assign axi.awaddr  = addr_r;
  assign axi.awlen   = LAST_BEAT;
  assign axi.awsize  = BEAT_SIZE;
  assign axi.awburst = AXI_BURST_INCR;
  assign axi.wvalid  = wvalid_r;
  assign axi.wdata   = pattern_s;
  assign axi.wstrb   = {(DATA_WIDTH/8){1'b1}};
  assign axi.wlast   = wvalid_r & beat_last_s;
  assign axi.bready  = bready_r;
  assign axi.arvalid = arvalid_r;
  assign axi.arid    = {ID_WIDTH{1'b0}};
  assign axi.araddr  = addr_r;
  assign axi.arlen   = LAST_BEAT;
  assign axi.arsize  = BEAT_SIZE;
  assign axi.arburst = AXI_BURST_INCR;
  assign axi.rready  = rready_r;

  assign busy        = busy_r;
  assign done        = done_r;
  assign pass        = pass_r;
  assign err_count   = err_cnt_r;
  assign unused_id_s = ^{axi.bid, axi.rid};
endmodule

// File: tb/tb_hbm_axi_traffic_gen.sv
// Randomized bench: AXI memory responder with fault injection, plus a
// pattern/address/error-count reference model of the traffic generator.
module tb_hbm_axi_traffic_gen;
  localparam int AW    = 33;
  localparam int DW    = 256;
  localparam int IW    = 9;
  localparam int BL    = 8;
  localparam int BYTES = BL * DW / 8;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [AW-1:0] base_addr;
  logic [15:0]   num_bursts;
  logic          busy, done, pass;
  logic [15:0]   err_count;

  hbm_axi_traffic_gen_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) axi ();

  hbm_axi_traffic_gen #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .BURST_LEN(BL)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_bursts(num_bursts),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count), .axi(axi)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int ready_pct, rand_faults, bresp_burst, rresp_burst, corrupt_burst, corrupt_beat;
  int aw_cnt, ar_cnt, w_beats, r_beats, exp_err, valid_seen;
  logic [AW-1:0] run_base;
  logic [AW-1:0] aw_log[$];
  logic [DW-1:0] mem [logic [AW-1:0]];

  task automatic check_eq(input string tag, input logic [263:0] obs, input logic [263:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_beat(input int n, input int b);
    logic [DW-1:0] v;
    for (int k = 0; k < DW / 32; k++) v[k*32 +: 32] = {n[15:0], b[7:0], k[7:0]};
    return v;
  endfunction

  function automatic logic [AW-1:0] exp_addr(input int n);
    return run_base + AW'(n) * AW'(BYTES);
  endfunction

  // Memory responder: samples on negedge, drives just after posedge.
  initial begin : responder
    int wr_beat, rd_burst, rd_beat, idx;
    bit r_active, b_issue, aw_wait, w_wait, ar_wait;
    logic [AW-1:0] w_addr, r_addr, aw_prev, ar_prev;
    logic [DW-1:0] w_prev, n_rd;
    logic wl_prev, n_awr, n_wr, n_arr, n_bv, n_rv, n_rl;
    logic [1:0] n_br, n_rr;
    {axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid, axi.rlast} = 6'd0;
    axi.bid = '0; axi.rid = '0; axi.bresp = 2'b00; axi.rresp = 2'b00; axi.rdata = '0;
    {r_active, b_issue, aw_wait, w_wait, ar_wait} = 5'd0;
    wr_beat = 0; rd_burst = 0; rd_beat = 0;
    forever begin
      @(negedge clk);
      {n_awr, n_wr, n_arr} = {axi.awready, axi.wready, axi.arready};
      n_bv = axi.bvalid; n_br = axi.bresp; n_rv = axi.rvalid;
      n_rd = axi.rdata; n_rr = axi.rresp; n_rl = axi.rlast;
      if (reset) begin
        {r_active, b_issue, aw_wait, w_wait, ar_wait} = 5'd0;
        {n_awr, n_wr, n_arr, n_bv, n_rv, n_rl} = 6'd0;
        n_br = 2'b00; n_rr = 2'b00;
      end else begin
        if (axi.awvalid | axi.wvalid | axi.arvalid) valid_seen++;
        if (aw_wait) check_eq("aw_hold", {axi.awvalid, axi.awaddr}, {1'b1, aw_prev});
        if (w_wait)  check_eq("w_hold", {axi.wvalid, axi.wlast, axi.wdata}, {1'b1, wl_prev, w_prev});
        if (ar_wait) check_eq("ar_hold", {axi.arvalid, axi.araddr}, {1'b1, ar_prev});
        aw_wait = axi.awvalid && !axi.awready; aw_prev = axi.awaddr;
        w_wait  = axi.wvalid && !axi.wready;   w_prev = axi.wdata; wl_prev = axi.wlast;
        ar_wait = axi.arvalid && !axi.arready; ar_prev = axi.araddr;
        if (axi.awvalid && axi.awready) begin
          check_eq("awaddr", axi.awaddr, exp_addr(aw_cnt));
          check_eq("aw_ctl", {axi.awid, axi.awlen, axi.awsize, axi.awburst}, {9'd0, 8'd7, 3'd5, 2'b01});
          aw_log.push_back(axi.awaddr);
          w_addr = axi.awaddr; wr_beat = 0; aw_cnt++;
        end
        if (axi.wvalid && axi.wready) begin
          check_eq("wdata", axi.wdata, exp_beat(aw_cnt - 1, wr_beat));
          check_eq("w_ctl", {axi.wlast, axi.wstrb}, {wr_beat == BL - 1, 32'hFFFF_FFFF});
          mem[w_addr + AW'(wr_beat * (DW / 8))] = axi.wdata;
          wr_beat++; w_beats++;
          if (wr_beat == BL) b_issue = 1'b1;
        end
        if (axi.bvalid && axi.bready) n_bv = 1'b0;
        if (b_issue) begin
          n_bv = 1'b1; n_br = 2'b00; b_issue = 1'b0;
          if ((aw_cnt - 1 == bresp_burst) || (rand_faults != 0 && $urandom_range(4) == 0)) begin
            n_br = 2'b10; exp_err++;
          end
        end
        if (axi.arvalid && axi.arready) begin
          check_eq("araddr", axi.araddr, exp_addr(ar_cnt));
          check_eq("ar_ctl", {axi.arid, axi.arlen, axi.arsize, axi.arburst}, {9'd0, 8'd7, 3'd5, 2'b01});
          r_addr = axi.araddr; rd_burst = ar_cnt; rd_beat = 0; r_active = 1'b1; ar_cnt++;
        end
        if (axi.rvalid && axi.rready) begin
          rd_beat++; r_beats++; n_rv = 1'b0;
          if (rd_beat == BL) r_active = 1'b0;
        end
        // Present the next read beat; faults are scored as they are presented.
        if (r_active && !n_rv && (rand_faults == 0 || $urandom_range(3) != 0)) begin
          n_rv = 1'b1;
          n_rd = mem.exists(r_addr + AW'(rd_beat * (DW / 8))) ? mem[r_addr + AW'(rd_beat * (DW / 8))] : '0;
          n_rr = 2'b00; n_rl = (rd_beat == BL - 1);
          if (rd_burst == corrupt_burst && rd_beat == corrupt_beat) begin n_rd[0] = ~n_rd[0]; exp_err++; end
          if (rd_burst == rresp_burst) begin n_rr = 2'b11; exp_err++; end
          if (rand_faults != 0) begin
            if ($urandom_range(9) == 0) begin idx = $urandom_range(DW - 1); n_rd[idx] = ~n_rd[idx]; exp_err++; end
            if (n_rr == 2'b00 && $urandom_range(9) == 0) begin n_rr = 2'b10; exp_err++; end
            if ($urandom_range(9) == 0) begin n_rl = ~n_rl; exp_err++; end
          end
        end
        n_awr = (int'($urandom_range(99)) < ready_pct);
        n_wr  = (int'($urandom_range(99)) < ready_pct);
        n_arr = (int'($urandom_range(99)) < ready_pct);
      end
      @(posedge clk); #1;
      {axi.awready, axi.wready, axi.arready} = {n_awr, n_wr, n_arr};
      axi.bvalid = n_bv; axi.bresp = n_br;
      axi.rvalid = n_rv; axi.rdata = n_rd; axi.rresp = n_rr; axi.rlast = n_rl;
    end
  end

  task automatic clear_model(input logic [AW-1:0] base);
    aw_cnt = 0; ar_cnt = 0; w_beats = 0; r_beats = 0; exp_err = 0; valid_seen = 0;
    run_base = base; aw_log.delete();
  endtask

  task automatic run_test(input string tag, input logic [AW-1:0] base, input int nb);
    int cyc;
    @(posedge clk); #1;
    clear_model(base);
    start = 1'b1; base_addr = base; num_bursts = nb[15:0];
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    if (nb == 0) check_eq({tag, "_zero"}, {done, pass, busy}, 3'b110);
    else         check_eq({tag, "_began"}, {done, busy}, 2'b01);
    if (nb > 0) begin
      // A start while busy must be ignored.
      @(posedge clk); #1;
      start = 1'b1; num_bursts = 16'd0; base_addr = ~base;
      @(posedge clk); #1;
      start = 1'b0;
    end
    cyc = 0;
    while (!done && cyc < 3000) begin @(negedge clk); cyc++; end
    #1;
    check_eq({tag, "_timeout"}, cyc < 3000, 1'b1);
    check_eq({tag, "_err"}, err_count, exp_err);
    check_eq({tag, "_status"}, {done, pass, busy}, {1'b1, exp_err == 0, 1'b0});
    check_eq({tag, "_bursts"}, {aw_cnt[15:0], ar_cnt[15:0]}, {nb[15:0], nb[15:0]});
    check_eq({tag, "_beats"}, {w_beats[15:0], r_beats[15:0]}, {16'(nb * BL), 16'(nb * BL)});
    if (nb == 0) check_eq({tag, "_novalid"}, valid_seen, 0);
    @(negedge clk);
    check_eq({tag, "_sticky"}, {done, busy}, 2'b10);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int cyc;
    logic [AW-1:0] rb;
    reset = 1'b1; start = 1'b0; base_addr = '0; num_bursts = 16'd0;
    ready_pct = 100; rand_faults = 0;
    bresp_burst = -1; rresp_burst = -1; corrupt_burst = -1; corrupt_beat = -1;
    clear_model('0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_state", {busy, done, pass, err_count, axi.awvalid, axi.wvalid, axi.arvalid,
                             axi.bready, axi.rready, axi.wlast}, 25'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    run_test("single", '0, 1);

    ready_pct = 50;
    run_test("backpressure", '0, 4);
    check_eq("bp_addrs", {aw_log[0], aw_log[1], aw_log[2], aw_log[3]},
             {33'h0, 33'h100, 33'h200, 33'h300});

    ready_pct = 100; corrupt_burst = 1; corrupt_beat = 3;
    run_test("corrupt", '0, 2);
    check_eq("corrupt_cnt", {err_count, pass}, {16'd1, 1'b0});
    corrupt_burst = -1; corrupt_beat = -1;

    bresp_burst = 0; rresp_burst = 0;
    run_test("resp_err", '0, 1);
    check_eq("resp_cnt", {err_count, pass}, {16'd9, 1'b0});
    bresp_burst = -1; rresp_burst = -1;

    run_test("wrap", 33'h1_FFFF_FF00, 2);
    check_eq("wrap_addrs", {aw_log[0], aw_log[1]}, {33'h1_FFFF_FF00, 33'h0});

    run_test("zero_len", 33'h40, 0);

    // Reset in the middle of the write burst, at beat 4.
    @(posedge clk); #1;
    clear_model('0);
    start = 1'b1; base_addr = '0; num_bursts = 16'd2;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (w_beats < 4 && cyc < 500) begin @(negedge clk); #2; cyc++; end
    check_eq("midrst_wait", cyc < 500, 1'b1);
    reset = 1'b1;
    #1;
    check_eq("midrst_drop", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready,
                             axi.wlast, busy, done}, 8'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; valid_seen = 0;
    repeat (10) @(negedge clk);
    check_eq("midrst_quiet", valid_seen, 0);
    run_test("after_rst", '0, 1);
    check_eq("after_rst_pass", pass, 1'b1);

    rand_faults = 1;
    for (int i = 0; i < 6; i++) begin
      ready_pct = $urandom_range(30, 100);
      rb = {1'($urandom), $urandom};
      rb[4:0] = 5'd0;
      run_test("random", rb, $urandom_range(1, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
